// File: rtl/gmm_param_fetch_ctrl.sv
// gmm_param_fetch_ctrl
//
// Streams pixels into a per-pixel GMM parameter read / update / write-back
// pipeline. Each accepted pixel issues a read to a simple dual-port
// parameter memory. The fetched word is paired with the pixel for an
// external fixed-latency update datapath. The updated word is then written
// back to the same address.
//
// Ports
//   clk_drv        in   rising-edge clock for all logic
//   reset          in   synchronous active-high reset
//   enable         in   global clock enable (also drives the memory); 0 holds everything
//   pix_valid      in   pixel qualifier
//   pix_sof        in   start of frame, qualified by pix_valid
//   pix_data       in   pixel intensity
//   sdpmem_rdaddr  out  memory read address (combinational)
//   sdpmem_rddata  in   memory read data, RD_LATENCY_p enabled cycles after rdaddr
//   sdpmem_wrena   out  memory write enable
//   sdpmem_wraddr  out  memory write address
//   sdpmem_wrdata  out  memory write data (combinational copy of upd_new_param)
//   upd_valid      out  pixel/parameter pair valid for the update datapath
//   upd_pix        out  pixel aligned with upd_param
//   upd_param      out  fetched parameter word (combinational copy of sdpmem_rddata)
//   upd_new_param  in   updated word, UPD_LATENCY_p enabled cycles after upd_valid
//   frame_done     out  one-cycle pulse after the last pixel of a frame is accepted
//   sync_err       out  sticky short-frame error, cleared only by reset
//
// The memory depth must exceed RD_LATENCY_p + UPD_LATENCY_p + 1. Under that
// condition a write-back always lands before the same address is read again,
// so no forwarding path is needed.

module gmm_param_fetch_ctrl #(
  parameter int DATAWIDTH_p   = 32,
  parameter int PIXWIDTH_p    = 8,
  parameter int MEM_DEPTH_p   = 153600,
  parameter int RD_LATENCY_p  = 1,
  parameter int UPD_LATENCY_p = 4,
  localparam int ADDRWIDTH_c  = (MEM_DEPTH_p > 1) ? $clog2(MEM_DEPTH_p) : 1
) (
  input  logic                   clk_drv,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  input  logic [PIXWIDTH_p-1:0]  pix_data,
  output logic [ADDRWIDTH_c-1:0] sdpmem_rdaddr,
  input  logic [DATAWIDTH_p-1:0] sdpmem_rddata,
  output logic                   sdpmem_wrena,
  output logic [ADDRWIDTH_c-1:0] sdpmem_wraddr,
  output logic [DATAWIDTH_p-1:0] sdpmem_wrdata,
  output logic                   upd_valid,
  output logic [PIXWIDTH_p-1:0]  upd_pix,
  output logic [DATAWIDTH_p-1:0] upd_param,
  input  logic [DATAWIDTH_p-1:0] upd_new_param,
  output logic                   frame_done,
  output logic                   sync_err
);

  localparam logic [ADDRWIDTH_c-1:0] LAST_ADDR_c = ADDRWIDTH_c'(MEM_DEPTH_p - 1);

  // ---------------------------------------------------------------------------
  // Address counter, frame pulse and sync error
  // ---------------------------------------------------------------------------
  logic [ADDRWIDTH_c-1:0] addr_cnt_reg, addr_cnt_next;
  logic [ADDRWIDTH_c-1:0] used_addr;
  logic                   frame_done_reg, frame_done_next;
  logic                   sync_err_reg, sync_err_next;

  // A start-of-frame pixel always restarts at address 0, even mid-frame.
  assign used_addr     = pix_sof ? '0 : addr_cnt_reg;
  assign sdpmem_rdaddr = used_addr;

  // Registers only advance when enable=1, so pix_valid alone qualifies
  // acceptance inside this block.
  always_comb begin
    addr_cnt_next   = addr_cnt_reg;
    frame_done_next = 1'b0;
    sync_err_next   = sync_err_reg;
    if (pix_valid) begin
      addr_cnt_next   = (used_addr == LAST_ADDR_c) ? '0 : used_addr + ADDRWIDTH_c'(1);
      frame_done_next = (used_addr == LAST_ADDR_c);
      // A start of frame before the counter has wrapped means the previous
      // frame was short.
      if (pix_sof && (addr_cnt_reg != '0)) begin
        sync_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_drv) begin
    if (reset) begin
      addr_cnt_reg   <= '0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else if (enable) begin
      addr_cnt_reg   <= addr_cnt_next;
      frame_done_reg <= frame_done_next;
      sync_err_reg   <= sync_err_next;
    end
  end

  assign frame_done = frame_done_reg;
  assign sync_err   = sync_err_reg;

  // ---------------------------------------------------------------------------
  // Read-side delay line: matches the memory read latency so the pixel and
  // the fetched word leave together.
  // ---------------------------------------------------------------------------
  logic                   rd_valid_reg [RD_LATENCY_p];
  logic [PIXWIDTH_p-1:0]  rd_pix_reg   [RD_LATENCY_p];
  logic [ADDRWIDTH_c-1:0] rd_addr_reg  [RD_LATENCY_p];
  logic                   rd_valid_next [RD_LATENCY_p];
  logic [PIXWIDTH_p-1:0]  rd_pix_next   [RD_LATENCY_p];
  logic [ADDRWIDTH_c-1:0] rd_addr_next  [RD_LATENCY_p];

  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY_p; gi++) begin : g_rd_stage
      if (gi == 0) begin : g_head
        assign rd_valid_next[gi] = pix_valid;
        assign rd_pix_next[gi]   = pix_data;
        assign rd_addr_next[gi]  = used_addr;
      end else begin : g_tail
        assign rd_valid_next[gi] = rd_valid_reg[gi-1];
        assign rd_pix_next[gi]   = rd_pix_reg[gi-1];
        assign rd_addr_next[gi]  = rd_addr_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_drv) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY_p; i++) begin
        rd_valid_reg[i] <= 1'b0;
        rd_pix_reg[i]   <= '0;
        rd_addr_reg[i]  <= '0;
      end
    end else if (enable) begin
      for (int i = 0; i < RD_LATENCY_p; i++) begin
        rd_valid_reg[i] <= rd_valid_next[i];
        rd_pix_reg[i]   <= rd_pix_next[i];
        rd_addr_reg[i]  <= rd_addr_next[i];
      end
    end
  end

  assign upd_valid = rd_valid_reg[RD_LATENCY_p-1];
  assign upd_pix   = rd_pix_reg[RD_LATENCY_p-1];
  assign upd_param = sdpmem_rddata;

  // ---------------------------------------------------------------------------
  // Write-side delay line: carries the address across the update datapath
  // latency so the write-back targets the address that was read.
  // ---------------------------------------------------------------------------
  logic                   wr_valid_reg  [UPD_LATENCY_p];
  logic [ADDRWIDTH_c-1:0] wr_addr_reg   [UPD_LATENCY_p];
  logic                   wr_valid_next [UPD_LATENCY_p];
  logic [ADDRWIDTH_c-1:0] wr_addr_next  [UPD_LATENCY_p];

  generate
    for (gi = 0; gi < UPD_LATENCY_p; gi++) begin : g_wr_stage
      if (gi == 0) begin : g_head
        assign wr_valid_next[gi] = rd_valid_reg[RD_LATENCY_p-1];
        assign wr_addr_next[gi]  = rd_addr_reg[RD_LATENCY_p-1];
      end else begin : g_tail
        assign wr_valid_next[gi] = wr_valid_reg[gi-1];
        assign wr_addr_next[gi]  = wr_addr_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_drv) begin
    if (reset) begin
      for (int i = 0; i < UPD_LATENCY_p; i++) begin
        wr_valid_reg[i] <= 1'b0;
        wr_addr_reg[i]  <= '0;
      end
    end else if (enable) begin
      for (int i = 0; i < UPD_LATENCY_p; i++) begin
        wr_valid_reg[i] <= wr_valid_next[i];
        wr_addr_reg[i]  <= wr_addr_next[i];
      end
    end
  end

  assign sdpmem_wrena  = wr_valid_reg[UPD_LATENCY_p-1];
  assign sdpmem_wraddr = wr_addr_reg[UPD_LATENCY_p-1];
  assign sdpmem_wrdata = upd_new_param;

endmodule

// File: tb/tb_gmm_param_fetch_ctrl.sv
module tb_gmm_param_fetch_ctrl;

  localparam int DW    = 32;
  localparam int PW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk_drv = 1'b0;
  logic          reset;
  logic          enable;
  logic          pix_valid;
  logic          pix_sof;
  logic [PW-1:0] pix_data;
  logic [DW-1:0] sdpmem_rddata;
  logic [DW-1:0] upd_new_param;

  logic [AW-1:0] sdpmem_rdaddr, sdpmem_wraddr;
  logic          sdpmem_wrena, upd_valid, frame_done, sync_err;
  logic [DW-1:0] sdpmem_wrdata, upd_param;
  logic [PW-1:0] upd_pix;

  logic [AW-1:0] d2_rdaddr, d2_wraddr;
  logic          d2_wrena, d2_upd_valid, d2_frame_done, d2_sync_err;
  logic [DW-1:0] d2_wrdata, d2_upd_param;
  logic [PW-1:0] d2_upd_pix;

  int checks = 0;
  int errors = 0;
  int unsigned cnum = 0;

  always #5 clk_drv = ~clk_drv;

  gmm_param_fetch_ctrl #(
    .DATAWIDTH_p(DW), .PIXWIDTH_p(PW), .MEM_DEPTH_p(DEPTH),
    .RD_LATENCY_p(1), .UPD_LATENCY_p(4)
  ) dut (
    .clk_drv(clk_drv), .reset(reset), .enable(enable),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .sdpmem_rdaddr(sdpmem_rdaddr), .sdpmem_rddata(sdpmem_rddata),
    .sdpmem_wrena(sdpmem_wrena), .sdpmem_wraddr(sdpmem_wraddr), .sdpmem_wrdata(sdpmem_wrdata),
    .upd_valid(upd_valid), .upd_pix(upd_pix), .upd_param(upd_param),
    .upd_new_param(upd_new_param), .frame_done(frame_done), .sync_err(sync_err)
  );

  gmm_param_fetch_ctrl #(
    .DATAWIDTH_p(DW), .PIXWIDTH_p(PW), .MEM_DEPTH_p(DEPTH),
    .RD_LATENCY_p(2), .UPD_LATENCY_p(4)
  ) dut2 (
    .clk_drv(clk_drv), .reset(reset), .enable(enable),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .sdpmem_rdaddr(d2_rdaddr), .sdpmem_rddata(sdpmem_rddata),
    .sdpmem_wrena(d2_wrena), .sdpmem_wraddr(d2_wraddr), .sdpmem_wrdata(d2_wrdata),
    .upd_valid(d2_upd_valid), .upd_pix(d2_upd_pix), .upd_param(d2_upd_param),
    .upd_new_param(upd_new_param), .frame_done(d2_frame_done), .sync_err(d2_sync_err)
  );

  // Drive one cycle of inputs just after a rising edge, then settle so the
  // caller can sample outputs mid-cycle.
  task automatic cyc(input logic en, input logic v, input logic sof, input logic [PW-1:0] pix);
    @(posedge clk_drv); #1;
    enable        = en;
    pix_valid     = v;
    pix_sof       = sof;
    pix_data      = pix;
    sdpmem_rddata = {16'hDA7A, cnum[15:0]};
    upd_new_param = {16'hC0DE, cnum[15:0]};
    cnum++;
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk_drv); #1;
    reset = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
    @(posedge clk_drv); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 8'd5);
    cyc(1, 1, 0, 8'd6);
    cyc(1, 1, 1, 8'd7);
    cyc(0, 0, 0, 8'd0);
    checks++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL reset_pre_sync_err got %0b exp 1", sync_err); end
    @(posedge clk_drv); #1;
    reset = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
    @(posedge clk_drv); #2;
    checks++;
    if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid got %0b exp 0", upd_valid); end
    checks++;
    if (sdpmem_wrena !== 1'b0) begin errors++; $display("FAIL reset_wrena got %0b exp 0", sdpmem_wrena); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b exp 0", frame_done); end
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %0b exp 0", sync_err); end
    checks++;
    if (sdpmem_rdaddr !== 4'd0) begin errors++; $display("FAIL reset_rdaddr got %0d exp 0", sdpmem_rdaddr); end
    checks++;
    if (d2_upd_valid !== 1'b0 || d2_wrena !== 1'b0) begin
      errors++; $display("FAIL reset_d2 got uv=%0b we=%0b exp 0 0", d2_upd_valid, d2_wrena);
    end
    reset = 1'b0;
  endtask

  // Three back-to-back pixels: fetch one cycle later, write-back five later.
  task automatic test_basic();
    logic exp_uv, exp_wr;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc(1, c < 3, c == 0, 8'(10 + c));
      if (c < 3) begin
        checks++;
        if (sdpmem_rdaddr !== AW'(c)) begin errors++; $display("FAIL basic_rdaddr c=%0d got %0d exp %0d", c, sdpmem_rdaddr, c); end
      end
      exp_uv = (c >= 1 && c <= 3);
      checks++;
      if (upd_valid !== exp_uv) begin errors++; $display("FAIL basic_upd_valid c=%0d got %0b exp %0b", c, upd_valid, exp_uv); end
      if (exp_uv) begin
        checks++;
        if (upd_pix !== 8'(10 + c - 1)) begin errors++; $display("FAIL basic_upd_pix c=%0d got %0d exp %0d", c, upd_pix, 10 + c - 1); end
        checks++;
        if (upd_param !== sdpmem_rddata) begin errors++; $display("FAIL basic_upd_param c=%0d got %h exp %h", c, upd_param, sdpmem_rddata); end
      end
      exp_wr = (c >= 5 && c <= 7);
      checks++;
      if (sdpmem_wrena !== exp_wr) begin errors++; $display("FAIL basic_wrena c=%0d got %0b exp %0b", c, sdpmem_wrena, exp_wr); end
      if (exp_wr) begin
        checks++;
        if (sdpmem_wraddr !== AW'(c - 5)) begin errors++; $display("FAIL basic_wraddr c=%0d got %0d exp %0d", c, sdpmem_wraddr, c - 5); end
        checks++;
        if (sdpmem_wrdata !== upd_new_param) begin errors++; $display("FAIL basic_wrdata c=%0d got %h exp %h", c, sdpmem_wrdata, upd_new_param); end
      end
    end
  endtask

  // 17 pixels into a 16-deep frame: wrap to 0, single frame_done, no error.
  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(1, c < 17, c == 0, 8'(c));
      if (c < 17) begin
        checks++;
        if (sdpmem_rdaddr !== AW'(c % 16)) begin errors++; $display("FAIL wrap_rdaddr c=%0d got %0d exp %0d", c, sdpmem_rdaddr, c % 16); end
      end
      checks++;
      if (frame_done !== (c == 16)) begin errors++; $display("FAIL wrap_frame_done c=%0d got %0b exp %0b", c, frame_done, c == 16); end
      checks++;
      if (sync_err !== 1'b0) begin errors++; $display("FAIL wrap_sync_err c=%0d got %0b exp 0", c, sync_err); end
    end
  endtask

  // Early sof after 5 pixels: restart at 0, sticky error until reset.
  task automatic test_sync_err();
    logic exp_wr;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      cyc(1, c <= 6, c == 0 || c == 5, 8'(c));
      if (c <= 6) begin
        checks++;
        if (sdpmem_rdaddr !== AW'(c < 5 ? c : c - 5)) begin
          errors++; $display("FAIL sync_rdaddr c=%0d got %0d exp %0d", c, sdpmem_rdaddr, c < 5 ? c : c - 5);
        end
      end
      checks++;
      if (sync_err !== (c >= 6)) begin errors++; $display("FAIL sync_err c=%0d got %0b exp %0b", c, sync_err, c >= 6); end
      exp_wr = (c >= 5 && c <= 11);
      checks++;
      if (sdpmem_wrena !== exp_wr) begin errors++; $display("FAIL sync_wrena c=%0d got %0b exp %0b", c, sdpmem_wrena, exp_wr); end
      if (exp_wr) begin
        checks++;
        if (sdpmem_wraddr !== AW'(c <= 9 ? c - 5 : c - 10)) begin
          errors++; $display("FAIL sync_wraddr c=%0d got %0d exp %0d", c, sdpmem_wraddr, c <= 9 ? c - 5 : c - 10);
        end
      end
    end
    do_reset();
    cyc(1, 0, 0, 8'd0);
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_err_cleared got %0b exp 0", sync_err); end
  endtask

  // Three disabled cycles mid-stream: outputs freeze, stream resumes intact.
  task automatic test_enable();
    int vc;
    logic exp_uv, exp_wr;
    logic en, v;
    logic [PW-1:0] pix;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      en  = !(c >= 4 && c <= 6);
      v   = (c <= 9);
      pix = (c <= 3) ? 8'(20 + c) : (c <= 6) ? 8'd99 : 8'(20 + c - 3);
      cyc(en, v, c == 0, pix);
      vc = (c <= 4) ? c : (c <= 7) ? 4 : c - 3;
      if (v) begin
        checks++;
        if (sdpmem_rdaddr !== AW'(vc)) begin errors++; $display("FAIL en_rdaddr c=%0d got %0d exp %0d", c, sdpmem_rdaddr, vc); end
      end
      exp_uv = (vc >= 1 && vc <= 7);
      checks++;
      if (upd_valid !== exp_uv) begin errors++; $display("FAIL en_upd_valid c=%0d got %0b exp %0b", c, upd_valid, exp_uv); end
      if (exp_uv) begin
        checks++;
        if (upd_pix !== 8'(20 + vc - 1)) begin errors++; $display("FAIL en_upd_pix c=%0d got %0d exp %0d", c, upd_pix, 20 + vc - 1); end
      end
      exp_wr = (vc >= 5 && vc <= 11);
      checks++;
      if (sdpmem_wrena !== exp_wr) begin errors++; $display("FAIL en_wrena c=%0d got %0b exp %0b", c, sdpmem_wrena, exp_wr); end
      if (exp_wr) begin
        checks++;
        if (sdpmem_wraddr !== AW'(vc - 5)) begin errors++; $display("FAIL en_wraddr c=%0d got %0d exp %0d", c, sdpmem_wraddr, vc - 5); end
      end
    end
  endtask

  // Reset with four pixels in flight: nothing written back, counter at 0.
  task automatic test_reset_flight();
    do_reset();
    for (int c = 0; c < 4; c++) cyc(1, 1, c == 0, 8'(30 + c));
    @(posedge clk_drv); #1;
    reset = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc(1, 0, 0, 8'd0);
      reset = 1'b0;
      checks++;
      if (upd_valid !== 1'b0 || sdpmem_wrena !== 1'b0) begin
        errors++; $display("FAIL flight_quiet c=%0d got uv=%0b we=%0b exp 0 0", c, upd_valid, sdpmem_wrena);
      end
    end
    cyc(1, 1, 0, 8'd55);
    checks++;
    if (sdpmem_rdaddr !== 4'd0) begin errors++; $display("FAIL flight_rdaddr got %0d exp 0", sdpmem_rdaddr); end
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 0, 0, 8'd0);
      checks++;
      if (sdpmem_wrena !== (k == 5)) begin errors++; $display("FAIL flight_wrena k=%0d got %0b exp %0b", k, sdpmem_wrena, k == 5); end
      if (k == 5) begin
        checks++;
        if (sdpmem_wraddr !== 4'd0) begin errors++; $display("FAIL flight_wraddr got %0d exp 0", sdpmem_wraddr); end
      end
    end
  endtask

  // Two-cycle read latency with alternating valid.
  task automatic test_rd2();
    logic v, exp_uv, exp_wr;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      v = (c < 8) && (c % 2 == 0);
      cyc(1, v, c == 0, 8'(40 + c));
      if (v) begin
        checks++;
        if (d2_rdaddr !== AW'(c / 2)) begin errors++; $display("FAIL rd2_rdaddr c=%0d got %0d exp %0d", c, d2_rdaddr, c / 2); end
      end
      exp_uv = (c >= 2) && (c - 2 < 8) && ((c - 2) % 2 == 0);
      checks++;
      if (d2_upd_valid !== exp_uv) begin errors++; $display("FAIL rd2_upd_valid c=%0d got %0b exp %0b", c, d2_upd_valid, exp_uv); end
      if (exp_uv) begin
        checks++;
        if (d2_upd_pix !== 8'(40 + c - 2)) begin errors++; $display("FAIL rd2_upd_pix c=%0d got %0d exp %0d", c, d2_upd_pix, 40 + c - 2); end
      end
      exp_wr = (c >= 6) && (c - 6 < 8) && ((c - 6) % 2 == 0);
      checks++;
      if (d2_wrena !== exp_wr) begin errors++; $display("FAIL rd2_wrena c=%0d got %0b exp %0b", c, d2_wrena, exp_wr); end
      if (exp_wr) begin
        checks++;
        if (d2_wraddr !== AW'((c - 6) / 2)) begin errors++; $display("FAIL rd2_wraddr c=%0d got %0d exp %0d", c, d2_wraddr, (c - 6) / 2); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    sdpmem_rddata = '0; upd_new_param = '0;
    repeat (3) @(posedge clk_drv);
    #1 reset = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_sync_err();
    test_enable();
    test_reset_flight();
    test_rd2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
